// File: rtl/t01_board_pkg.sv
// Shared board geometry, game-state codes, lock FSM states and the
// cell addressing helper for the t01 board pipeline.
package t01_board_pkg;

  localparam int ROWS    = 20;
  localparam int COLS    = 10;
  localparam int COLOR_W = 3;
  localparam int CELLS   = ROWS * COLS;
  localparam int IDX_W   = $clog2(CELLS);

  localparam logic [3:0] GS_RESTART = 4'd9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_MERGE,
    ST_EVAL_START,
    ST_EVAL_WAIT,
    ST_COMMIT,
    ST_DONE,
    ST_ERROR
  } lock_state_t;

  // One colour field per cell; element i sits at bits [COLOR_W*i +: COLOR_W]
  // of the flat port vectors.
  typedef logic [CELLS-1:0][COLOR_W-1:0] color_arr_t;

  // Flat board index of (row, col); row 0 is the top row.
  function automatic logic [IDX_W-1:0] cell_index(input logic [5:0] row,
                                                  input logic [5:0] col);
    return IDX_W'(int'(row) * COLS + int'(col));
  endfunction

endpackage

// File: rtl/t01_piece_fit.sv
// Combinational fit evaluator: places a 4x4 piece mask on the stack,
// reports out-of-bounds / overlap and produces the merged arrays.
module t01_piece_fit
  import t01_board_pkg::*;
(
  input  logic [15:0]        i_mask,
  input  logic [4:0]         i_row,
  input  logic [3:0]         i_col,
  input  logic [COLOR_W-1:0] i_color,
  input  logic [CELLS-1:0]   i_stack,
  input  color_arr_t         i_stack_color,
  output logic               o_oob,
  output logic               o_overlap,
  output logic [CELLS-1:0]   o_merged,
  output color_arr_t         o_merged_color
);

  logic [5:0]       w_row;
  logic [5:0]       w_col;
  logic [3:0]       w_bit;
  logic [IDX_W-1:0] w_idx;

  // Walk all 16 mask cells; board coordinates are 6 bits wide so a piece
  // hanging past the edge is caught instead of wrapping onto the board.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    o_oob          = 1'b0;
    o_overlap      = 1'b0;
    o_merged       = i_stack;
    o_merged_color = i_stack_color;
    w_row          = '0;
    w_col          = '0;
    w_bit          = '0;
    w_idx          = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        w_bit = 4'(4 * r + c);
        w_row = {1'b0, i_row} + 6'(r);
        w_col = {2'b00, i_col} + 6'(c);
        if (i_mask[w_bit]) begin
          if (w_row >= 6'(ROWS) || w_col >= 6'(COLS)) begin
            o_oob = 1'b1;
          end else begin
            w_idx = cell_index(w_row, w_col);
            if (i_stack[w_idx]) o_overlap = 1'b1;
            o_merged[w_idx]       = 1'b1;
            o_merged_color[w_idx] = i_color;
          end
        end
      end
    end
  end

endmodule

// File: rtl/t01_piece_lock.sv
// Piece lock stage: checks and merges a landed piece into the owned stack,
// hands the board to t01_lineclear, commits its result and tracks game over.
module t01_piece_lock
  import t01_board_pkg::*;
#(
  parameter int EVAL_TIMEOUT = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [3:0]                 i_gamestate,
  input  logic                       i_lock_req,
  input  logic [15:0]                i_piece_mask,
  input  logic [4:0]                 i_piece_row,
  input  logic [3:0]                 i_piece_col,
  input  logic [COLOR_W-1:0]         i_piece_color,
  input  logic                       i_eval_complete,
  input  logic [CELLS-1:0]           i_lc_array,
  input  logic [CELLS*COLOR_W-1:0]   i_lc_color_array,
  output logic                       o_start_eval,
  output logic [CELLS-1:0]           o_stack_array,
  output logic [CELLS*COLOR_W-1:0]   o_stack_color_array,
  output logic                       o_busy,
  output logic                       o_lock_done,
  output logic                       o_lock_error,
  output logic                       o_game_over
);

  localparam int CNT_W = (EVAL_TIMEOUT > 1) ? $clog2(EVAL_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(EVAL_TIMEOUT - 1);

  lock_state_t          r_state;
  lock_state_t          w_next;
  logic [15:0]          r_mask;
  logic [4:0]           r_row;
  logic [3:0]           r_col;
  logic [COLOR_W-1:0]   r_color;
  logic [CELLS-1:0]     r_stack;
  color_arr_t           r_stack_color;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_game_over;
  logic                 r_err_overlap;

  logic                 w_restart;
  logic                 w_oob;
  logic                 w_overlap;
  logic [CELLS-1:0]     w_merged;
  color_arr_t           w_merged_color;

  assign w_restart = (i_gamestate == GS_RESTART);

  t01_piece_fit u_fit (
    .i_mask         (r_mask),
    .i_row          (r_row),
    .i_col          (r_col),
    .i_color        (r_color),
    .i_stack        (r_stack),
    .i_stack_color  (r_stack_color),
    .o_oob          (w_oob),
    .o_overlap      (w_overlap),
    .o_merged       (w_merged),
    .o_merged_color (w_merged_color)
  );

  // State register; a restart game state aborts whatever is in flight.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples pre-edge values regardless of block ordering.
    if (reset)          r_state <= ST_IDLE;
    else if (w_restart) r_state <= ST_IDLE;
    else                r_state <= w_next;
  end

  // Next-state decode and single-cycle handshake/status pulses.
  always_comb begin
    w_next       = r_state;
    o_start_eval = 1'b0;
    o_lock_done  = 1'b0;
    o_lock_error = 1'b0;
    case (r_state)
      ST_IDLE:       if (i_lock_req && !r_game_over) w_next = ST_CHECK;
      ST_CHECK:      w_next = (w_oob || w_overlap) ? ST_ERROR : ST_MERGE;
      ST_MERGE:      w_next = ST_EVAL_START;
      ST_EVAL_START: begin
        o_start_eval = 1'b1;
        w_next       = ST_EVAL_WAIT;
      end
      ST_EVAL_WAIT: begin
        if (i_eval_complete)        w_next = ST_COMMIT;
        else if (r_cnt == CNT_LAST) w_next = ST_ERROR;
      end
      ST_COMMIT:     w_next = ST_DONE;
      ST_DONE: begin
        o_lock_done = 1'b1;
        w_next      = ST_IDLE;
      end
      ST_ERROR: begin
        o_lock_error = 1'b1;
        w_next       = ST_IDLE;
      end
      default:       w_next = ST_IDLE;
    endcase
    // A restart cycle must not leak a pulse from the state being aborted.
    if (w_restart) begin
      o_start_eval = 1'b0;
      o_lock_done  = 1'b0;
      o_lock_error = 1'b0;
    end
  end

  // Request capture, stack arrays, eval timeout counter and game-over flag.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: the stack arrays are board state the game reads directly, so
    // they are cleared by reset rather than left as uninitialised storage.
    if (reset || w_restart) begin
      r_mask        <= '0;
      r_row         <= '0;
      r_col         <= '0;
      r_color       <= '0;
      r_stack       <= '0;
      r_stack_color <= '0;
      r_cnt         <= '0;
      r_game_over   <= 1'b0;
      r_err_overlap <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_lock_req && !r_game_over) begin
            r_mask  <= i_piece_mask;
            r_row   <= i_piece_row;
            r_col   <= i_piece_col;
            r_color <= i_piece_color;
          end
        end
        ST_CHECK:      r_err_overlap <= w_overlap;
        ST_MERGE: begin
          r_stack       <= w_merged;
          r_stack_color <= w_merged_color;
          // A timeout error later in this lock must not end the game.
          r_err_overlap <= 1'b0;
        end
        ST_EVAL_START: r_cnt <= '0;
        ST_EVAL_WAIT:  if (!i_eval_complete && r_cnt != CNT_LAST) r_cnt <= r_cnt + 1'b1;
        ST_COMMIT: begin
          r_stack       <= i_lc_array;
          r_stack_color <= i_lc_color_array;
          if (|i_lc_array[COLS-1:0]) r_game_over <= 1'b1;
        end
        ST_ERROR:      if (r_err_overlap) r_game_over <= 1'b1;
        default: ;
      endcase
    end
  end

  assign o_stack_array       = r_stack;
  assign o_stack_color_array = r_stack_color;
  assign o_busy              = (r_state != ST_IDLE);
  assign o_game_over         = r_game_over;

endmodule

// File: tb/tb_t01_piece_lock.sv
// Directed bench for t01_piece_lock; the bench plays the role of
// t01_lineclear, returning hand-computed cleared arrays.
module tb_t01_piece_lock;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   gamestate;
  logic         lock_req;
  logic [15:0]  piece_mask;
  logic [4:0]   piece_row;
  logic [3:0]   piece_col;
  logic [2:0]   piece_color;
  logic         eval_complete;
  logic [199:0] lc_array;
  logic [599:0] lc_color_array;
  logic         start_eval;
  logic [199:0] stack_array;
  logic [599:0] stack_color_array;
  logic         busy;
  logic         lock_done;
  logic         lock_error;
  logic         game_over;

  int total = 0;
  int bad   = 0;

  logic [199:0] exp_stack;
  logic [599:0] exp_color;

  always #5 clk = ~clk;

  t01_piece_lock dut (
    .clk                 (clk),
    .reset               (reset),
    .i_gamestate         (gamestate),
    .i_lock_req          (lock_req),
    .i_piece_mask        (piece_mask),
    .i_piece_row         (piece_row),
    .i_piece_col         (piece_col),
    .i_piece_color       (piece_color),
    .i_eval_complete     (eval_complete),
    .i_lc_array          (lc_array),
    .i_lc_color_array    (lc_color_array),
    .o_start_eval        (start_eval),
    .o_stack_array       (stack_array),
    .o_stack_color_array (stack_color_array),
    .o_busy              (busy),
    .o_lock_done         (lock_done),
    .o_lock_error        (lock_error),
    .o_game_over         (game_over)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [599:0] observed,
                       input logic [599:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic put_cell(input int idx, input logic [2:0] color);
    exp_stack[idx]          = 1'b1;
    exp_color[idx*3 +: 3]   = color;
  endtask

  task automatic drive_lock(input logic [15:0] mask, input logic [4:0] row,
                            input logic [3:0] col, input logic [2:0] color);
    piece_mask  = mask;
    piece_row   = row;
    piece_col   = col;
    piece_color = color;
    lock_req    = 1'b1;
  endtask

  // Successful lock: lock_req at cycle 0, start_eval at 3, eval_complete
  // at 5, commit at 6, lock_done at 7. merged_* is the stack expected after
  // MERGE; lc_* is what the stand-in lineclear returns.
  task automatic lock_ok(input string tag, input logic [15:0] mask,
                         input logic [4:0] row, input logic [3:0] col,
                         input logic [2:0] color,
                         input logic [199:0] merged, input logic [599:0] merged_c,
                         input logic [199:0] lc, input logic [599:0] lc_c);
    drive_lock(mask, row, col, color);
    tick();                                   // cycle 1
    lock_req = 1'b0;
    check({tag, "_busy1"}, busy, 1'b1);
    tick();                                   // cycle 2
    check({tag, "_se_c2"}, start_eval, 1'b0);
    tick();                                   // cycle 3
    check({tag, "_se_c3"}, start_eval, 1'b1);
    check({tag, "_merged"}, stack_array, merged);
    check({tag, "_merged_c"}, stack_color_array, merged_c);
    tick();                                   // cycle 4
    check({tag, "_se_c4"}, start_eval, 1'b0);
    tick();                                   // cycle 5
    eval_complete  = 1'b1;
    lc_array       = lc;
    lc_color_array = lc_c;
    tick();                                   // cycle 6
    eval_complete = 1'b0;
    check({tag, "_done_c6"}, lock_done, 1'b0);
    tick();                                   // cycle 7
    check({tag, "_done_c7"}, lock_done, 1'b1);
    check({tag, "_commit"}, stack_array, lc);
    check({tag, "_commit_c"}, stack_color_array, lc_c);
    tick();                                   // cycle 8
    check({tag, "_idle"}, busy, 1'b0);
    check({tag, "_done_c8"}, lock_done, 1'b0);
  endtask

  task automatic restart();
    gamestate = 4'd9;
    tick();
    gamestate = 4'd0;
  endtask

  initial begin
    logic [199:0] merged;
    logic [599:0] merged_c;
    reset          = 1'b1;
    gamestate      = 4'd0;
    lock_req       = 1'b0;
    piece_mask     = '0;
    piece_row      = '0;
    piece_col      = '0;
    piece_color    = '0;
    eval_complete  = 1'b0;
    lc_array       = '0;
    lc_color_array = '0;
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Reset state
    check("rst_stack", stack_array, '0);
    check("rst_color", stack_color_array, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_go", game_over, 1'b0);
    check("rst_pulses", {start_eval, lock_done, lock_error}, 3'b000);

    // 2x2 square at the bottom-left of an empty board; lineclear echoes.
    exp_stack = '0;
    exp_color = '0;
    put_cell(180, 3'd2); put_cell(181, 3'd2);
    put_cell(190, 3'd2); put_cell(191, 3'd2);
    lock_ok("sq", 16'h0033, 5'd18, 4'd0, 3'd2, exp_stack, exp_color, exp_stack, exp_color);
    check("sq_go", game_over, 1'b0);

    // Restart while idle clears the board.
    restart();
    check("rs1_stack", stack_array, '0);
    check("rs1_color", stack_color_array, '0);

    // Preset row 19 columns 0-5 with two locks.
    exp_stack = '0;
    exp_color = '0;
    put_cell(190, 3'd1); put_cell(191, 3'd1); put_cell(192, 3'd1); put_cell(193, 3'd1);
    lock_ok("pre_a", 16'h000F, 5'd19, 4'd0, 3'd1, exp_stack, exp_color, exp_stack, exp_color);
    put_cell(194, 3'd4); put_cell(195, 3'd4);
    lock_ok("pre_b", 16'h0003, 5'd19, 4'd4, 3'd4, exp_stack, exp_color, exp_stack, exp_color);

    // Complete row 19 (columns 6-9 touch the right edge); lineclear
    // returns an empty board since nothing sits above row 19.
    merged   = exp_stack;
    merged_c = exp_color;
    for (int i = 196; i <= 199; i++) begin
      merged[i]         = 1'b1;
      merged_c[i*3 +: 3] = 3'd5;
    end
    lock_ok("line", 16'h000F, 5'd19, 4'd6, 3'd5, merged, merged_c, '0, '0);
    check("line_go", game_over, 1'b0);

    // Out of bounds: columns 7-10.
    drive_lock(16'h000F, 5'd19, 4'd7, 3'd3);
    tick();                                   // cycle 1
    lock_req = 1'b0;
    check("oob_err_c1", lock_error, 1'b0);
    tick();                                   // cycle 2
    check("oob_err_c2", lock_error, 1'b1);
    check("oob_se_c2", start_eval, 1'b0);
    tick();                                   // cycle 3
    check("oob_err_c3", lock_error, 1'b0);
    check("oob_se_c3", start_eval, 1'b0);
    check("oob_busy", busy, 1'b0);
    check("oob_stack", stack_array, '0);
    check("oob_go", game_over, 1'b0);

    // Preset cell 185 (row 18, col 5), then lock onto it again.
    exp_stack = '0;
    exp_color = '0;
    put_cell(185, 3'd6);
    lock_ok("pre185", 16'h0001, 5'd18, 4'd5, 3'd6, exp_stack, exp_color, exp_stack, exp_color);
    drive_lock(16'h0001, 5'd18, 4'd5, 3'd1);
    tick();                                   // cycle 1
    lock_req = 1'b0;
    tick();                                   // cycle 2
    check("ovl_err_c2", lock_error, 1'b1);
    tick();                                   // cycle 3
    check("ovl_go", game_over, 1'b1);
    check("ovl_stack", stack_array, exp_stack);
    check("ovl_color", stack_color_array, exp_color);
    // Further requests are ignored once the game is over.
    drive_lock(16'h0001, 5'd0, 4'd0, 3'd1);
    tick();
    lock_req = 1'b0;
    check("go_ign_busy1", busy, 1'b0);
    tick();
    check("go_ign_busy2", busy, 1'b0);
    check("go_ign_err", lock_error, 1'b0);

    // Restart clears game over and the board.
    restart();
    check("rs2_go", game_over, 1'b0);
    check("rs2_stack", stack_array, '0);

    // Timeout: start_eval at cycle 3, 64 EVAL_WAIT cycles, lock_error at 68.
    exp_stack = '0;
    exp_color = '0;
    put_cell(103, 3'd7);
    drive_lock(16'h0001, 5'd10, 4'd3, 3'd7);
    tick();
    lock_req = 1'b0;
    tick();
    tick();                                   // cycle 3
    check("to_se", start_eval, 1'b1);
    for (int k = 1; k <= 64; k++) begin
      tick();                                 // cycles 4..67
      check("to_wait_err", lock_error, 1'b0);
    end
    check("to_wait_busy", busy, 1'b1);
    tick();                                   // cycle 68
    check("to_err", lock_error, 1'b1);
    tick();
    check("to_idle", busy, 1'b0);
    check("to_keep", stack_array, exp_stack);
    check("to_keep_c", stack_color_array, exp_color);
    check("to_go", game_over, 1'b0);

    // Restart during EVAL_WAIT aborts the lock; late eval_complete ignored.
    drive_lock(16'h0001, 5'd5, 4'd5, 3'd3);
    tick();
    lock_req = 1'b0;
    tick();
    tick();                                   // cycle 3
    tick();                                   // cycle 4, EVAL_WAIT
    check("ab_busy_pre", busy, 1'b1);
    restart();
    check("ab_stack", stack_array, '0);
    check("ab_color", stack_color_array, '0);
    check("ab_busy", busy, 1'b0);
    check("ab_go", game_over, 1'b0);
    check("ab_done", lock_done, 1'b0);
    eval_complete  = 1'b1;
    lc_array       = '1;
    lc_color_array = '1;
    tick();
    eval_complete = 1'b0;
    check("ab_late_busy", busy, 1'b0);
    check("ab_late_done", lock_done, 1'b0);
    tick();
    check("ab_late_done2", lock_done, 1'b0);
    check("ab_late_stack", stack_array, '0);
    check("ab_late_go", game_over, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
